// File: rtl/mul_r1_r2_r3.sv
// Registered WIDTH x WIDTH multiplier returning the low half of the product
// plus n/z/c/v status flags, one result per clock with single-cycle latency.
module mul_r1_r2_r3 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r1,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   hi_u;
    logic [WIDTH-1:0]   hi_s;
    logic [WIDTH-1:0]   corr_a;
    logic [WIDTH-1:0]   corr_b;
    logic [WIDTH-1:0]   r1_next;
    logic               n_next;
    logic               z_next;
    logic               c_next;
    logic               v_next;

    // One unsigned multiplier serves both views; the signed high half is the
    // unsigned high half minus each operand wherever the other is negative.
    assign prod_u = {{WIDTH{1'b0}}, r2} * {{WIDTH{1'b0}}, r3};
    assign hi_u   = prod_u[2*WIDTH-1:WIDTH];
    assign corr_a = r2[WIDTH-1] ? r3 : '0;
    assign corr_b = r3[WIDTH-1] ? r2 : '0;
    assign hi_s   = hi_u - corr_a - corr_b;

    always_comb begin
        r1_next = prod_u[WIDTH-1:0];
        n_next  = r1_next[WIDTH-1];
        z_next  = (r1_next == '0);
        c_next  = (hi_u != '0);
        v_next  = (hi_s != {WIDTH{r1_next[WIDTH-1]}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= '0;
            n  <= 1'b0;
            z  <= 1'b0;
            c  <= 1'b0;
            v  <= 1'b0;
        end else begin
            r1 <= r1_next;
            n  <= n_next;
            z  <= z_next;
            c  <= c_next;
            v  <= v_next;
        end
    end

endmodule

// File: tb/tb_mul_r1_r2_r3.sv
// Directed bench for mul_r1_r2_r3: hand-computed products and flags.
module tb_mul_r1_r2_r3;

    logic        clk;
    logic        rst;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r1;
    logic        n;
    logic        z;
    logic        c;
    logic        v;

    int tests_run;
    int tests_failed;

    mul_r1_r2_r3 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .r2 (r2),
        .r3 (r3),
        .r1 (r1),
        .n  (n),
        .z  (z),
        .c  (c),
        .v  (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        r2  = 32'd0;
        r3  = 32'd0;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({r1, n, z, c, v} !== {32'd0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_async: got r1=%08h nzcv=%b%b%b%b want r1=00000000 nzcv=0000", r1, n, z, c, v);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if ({r1, n, z, c, v} !== {32'd0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_held: got r1=%08h nzcv=%b%b%b%b want r1=00000000 nzcv=0000", r1, n, z, c, v);
        end
        $display("[TB] reset: r1=%08h nzcv=%b%b%b%b", r1, n, z, c, v);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a   [4] = '{32'd1, 32'd2, 32'd4, 32'd3};
        logic [31:0] exp [4] = '{32'd1, 32'd4, 32'd16, 32'd9};
        for (int i = 0; i < 4; i++) begin
            r2 = a[i];
            r3 = a[i];
            @(posedge clk);
            #1;
            tests_run++;
            if ({r1, n, z, c, v} !== {exp[i], 4'b0000}) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got r1=%08h nzcv=%b%b%b%b want r1=%08h nzcv=0000",
                         i, r1, n, z, c, v, exp[i]);
            end
            $display("[TB] b2b %0d*%0d -> r1=%08h nzcv=%b%b%b%b", a[i], a[i], r1, n, z, c, v);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] a   [7] = '{32'h40000000, 32'h80000000, 32'hFFFFFFFF, 32'h00010000,
                                 32'h00000000, 32'hFFFFFFFD, 32'h00012345};
        logic [31:0] b   [7] = '{32'h40000000, 32'h80000000, 32'hFFFFFFFF, 32'h00008000,
                                 32'hFFFFFFFF, 32'h00000005, 32'h00000010};
        logic [31:0] exp [7] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h80000000,
                                 32'h00000000, 32'hFFFFFFF1, 32'h00123450};
        logic [3:0]  fl  [7] = '{4'b0111, 4'b0111, 4'b0010, 4'b1001,
                                 4'b0100, 4'b1010, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            r2 = a[i];
            r3 = b[i];
            @(posedge clk);
            #1;
            tests_run++;
            if ({r1, n, z, c, v} !== {exp[i], fl[i]}) begin
                tests_failed++;
                $display("FAIL boundary[%0d] %08h*%08h: got r1=%08h nzcv=%b%b%b%b want r1=%08h nzcv=%b",
                         i, a[i], b[i], r1, n, z, c, v, exp[i], fl[i]);
            end
            $display("[TB] %08h*%08h -> r1=%08h nzcv=%b%b%b%b", a[i], b[i], r1, n, z, c, v);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        r2 = 32'd6;
        r3 = 32'd7;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({r1, n, z, c, v} !== {32'd0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL mid_reset_clear: got r1=%08h nzcv=%b%b%b%b want r1=00000000 nzcv=0000", r1, n, z, c, v);
        end
        $display("[TB] mid-stream reset -> r1=%08h nzcv=%b%b%b%b", r1, n, z, c, v);
        r2 = 32'd5;
        r3 = 32'd7;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({r1, n, z, c, v} !== {32'd35, 4'b0000}) begin
            tests_failed++;
            $display("FAIL post_reset_5x7: got r1=%08h nzcv=%b%b%b%b want r1=00000023 nzcv=0000", r1, n, z, c, v);
        end
        $display("[TB] 5*7 after reset -> r1=%08h nzcv=%b%b%b%b", r1, n, z, c, v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_back_to_back();
        test_boundaries();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
